// File: rtl/serial_compare_scheduler_pkg.sv
// Shared types and result encodings for the serial compare scheduler.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    ST_EQUAL,
    ST_LESS,
    ST_GREATER
  } cmp_state_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sched_state_t;

  localparam logic [2:0] RES_LESS = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b001;

  function automatic logic [2:0] cmp_encode(
    input cmp_state_t s
  );
    case (s)
      ST_LESS:    return RES_LESS;
      ST_GREATER: return RES_GT;
      default:    return RES_EQ;
    endcase
  endfunction

endpackage

// File: rtl/serial_compare_scheduler_if.sv
// Request/response bundle between clients and the compare scheduler.
interface serial_compare_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int W     = 16
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IW-1:0]      rsp_id;
  logic [2:0]         rsp_result;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id,
    input  rsp_result, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id,
    output rsp_result, busy
  );

endinterface

// File: rtl/serial_cmp_msb_core.sv
// MSB-first magnitude compare FSM; first differing bit decides and sticks.
module serial_cmp_msb_core
  import serial_cmp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_a,
  input  logic       i_b,
  output cmp_state_t o_state
);

  cmp_state_t r_state;
  cmp_state_t w_nxt;

  always_comb begin
    w_nxt = r_state;
    if (r_state == ST_EQUAL) begin
      if (~i_a & i_b)
        w_nxt = ST_LESS;
      else if (i_a & ~i_b)
        w_nxt = ST_GREATER;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= ST_EQUAL;
    else if (i_clr)
      r_state <= ST_EQUAL;
    else if (i_en)
      r_state <= w_nxt;
  end

  assign o_state = r_state;

endmodule

// File: rtl/serial_compare_scheduler.sv
// Round-robin front end sharing one serial comparator among N_REQ clients.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish on the first differing bit.
module serial_compare_scheduler
  import serial_cmp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 16
) (
  input logic clk,
  input logic rst,
  serial_compare_scheduler_if.slave bus
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(W);

  sched_state_t r_state;
  sched_state_t w_next;

  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_id;
  logic [IW-1:0]    w_gnt;
  logic             w_found;
  logic             w_acc;
  logic             w_last;
  logic             w_fin;
  logic [N_REQ-1:0] w_ready;
  logic [W-1:0]     r_sh_a;
  logic [W-1:0]     r_sh_b;
  logic [CW-1:0]    r_cnt;
  cmp_state_t       w_cmp;

  always_comb begin
    int idx;
    w_found = 1'b0;
    w_gnt   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= N_REQ)
        idx = idx - N_REQ;
      if (!w_found && bus.req_valid[idx]) begin
        w_found = 1'b1;
        w_gnt   = IW'(idx);
      end
    end
  end

  // rst gates the grant so req_ready drops the instant reset asserts
  assign w_acc  = rst & (r_state == IDLE) & w_found;
  assign w_last = (r_cnt == CW'(W-1));

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  logic w_diff;
  assign w_diff = (w_cmp == ST_EQUAL) &
                  (r_sh_a[W-1] ^ r_sh_b[W-1]);
  assign w_fin  = w_last | w_diff;
`else
  assign w_fin  = w_last;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = '0;
    unique case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_ready[w_gnt] = 1'b1;
          w_next         = SHIFT;
        end
      end
      SHIFT: begin
        if (w_fin)
          w_next = DONE;
      end
      DONE: begin
        if (bus.rsp_ready)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr  <= '0;
      r_id   <= '0;
      r_sh_a <= '0;
      r_sh_b <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_acc) begin
        r_sh_a <= bus.req_a[w_gnt*W +: W];
        r_sh_b <= bus.req_b[w_gnt*W +: W];
        r_id   <= w_gnt;
        r_cnt  <= '0;
      end else if (r_state == SHIFT) begin
        r_sh_a <= r_sh_a << 1;
        r_sh_b <= r_sh_b << 1;
        r_cnt  <= r_cnt + 1'b1;
      end
      if (r_state == DONE && bus.rsp_ready)
        r_ptr <= (r_id == IW'(N_REQ-1)) ?
                 '0 : r_id + 1'b1;
    end
  end

  serial_cmp_msb_core u_core (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_acc),
    .i_en    (r_state == SHIFT),
    .i_a     (r_sh_a[W-1]),
    .i_b     (r_sh_b[W-1]),
    .o_state (w_cmp)
  );

  assign bus.req_ready  = w_ready;
  assign bus.rsp_valid  = (r_state == DONE);
  assign bus.rsp_id     = r_id;
  assign bus.rsp_result = (r_state == DONE) ?
                          cmp_encode(w_cmp) : 3'b000;
  assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_serial_compare_scheduler.sv
// Randomized bench for serial_compare_scheduler with a transaction-level
// model of arbitration order, compare result and response latency.
module tb_serial_compare_scheduler;

  localparam int N = 4;
  localparam int W = 16;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_compare_scheduler_if #(.N_REQ(N), .W(W)) bus ();

  serial_compare_scheduler #(.N_REQ(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int rr     = 0;

  logic         pend_v [N];
  logic [W-1:0] pend_a [N];
  logic [W-1:0] pend_b [N];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    for (int k = W-1; k >= 0; k--)
      if (a[k] != b[k])
        return EARLY ? (W - k) : W;
    return W;
  endfunction

  function automatic logic [2:0] exp_res(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    if (a < b)  return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int pick();
    for (int i = 0; i < N; i++) begin
      int id;
      id = (rr + i) % N;
      if (pend_v[id]) return id;
    end
    return -1;
  endfunction

  task automatic set_req(input int id,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b);
    pend_v[id] = 1'b1;
    pend_a[id] = a;
    pend_b[id] = b;
    bus.req_valid[id] = 1'b1;
    bus.req_a[id*W +: W] = a;
    bus.req_b[id*W +: W] = b;
  endtask

  task automatic drop_req(input int id);
    pend_v[id] = 1'b0;
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic gen(output logic [W-1:0] a,
                     output logic [W-1:0] b);
    int mode;
    mode = $urandom_range(0, 2);
    a = W'($urandom);
    case (mode)
      0: b = a;
      1: b = W'($urandom);
      default: b = a ^ (W'(1) << $urandom_range(0, W-1));
    endcase
  endtask

  // Entered at/after a negedge with state IDLE and requests pending.
  task automatic serve(input int g, input int stall);
    logic [N-1:0] onehot;
    logic [2:0]   er;
    int           el;
    int           n;
    bit           bad;
    #1;
    onehot    = '0;
    onehot[g] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(onehot));
    er = exp_res(pend_a[g], pend_b[g]);
    el = exp_lat(pend_a[g], pend_b[g]);
    @(posedge clk);
    #1;
    drop_req(g);
    bus.req_a[g*W +: W] = ~pend_a[g];
    bus.req_b[g*W +: W] = ~pend_b[g];
    n   = 0;
    bad = 1'b0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.req_ready != '0 || !bus.busy) bad = 1'b1;
    end while (!bus.rsp_valid && n <= W + 2);
    chk("latency", 32'(n), 32'(el));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_id", 32'(bus.rsp_id), 32'(g));
    chk("rsp_result", 32'(bus.rsp_result), 32'(er));
    chk("shift_ready_busy", 32'(bad), 32'd0);
    bad = 1'b0;
    repeat (stall) begin
      @(posedge clk);
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_id != g ||
          bus.rsp_result != er || bus.req_ready != '0)
        bad = 1'b1;
    end
    if (stall > 0) chk("stall_hold", 32'(bad), 32'd0);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_clr", 32'(bus.rsp_valid), 32'd0);
    chk("busy_clr", 32'(bus.busy), 32'd0);
    rr = (g + 1) % N;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_id"}, 32'(bus.rsp_id), 32'd0);
    chk({tag, "_result"}, 32'(bus.rsp_result), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           bad;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;

    // reset with all requesters already asking
    for (int i = 0; i < N; i++) begin
      gen(a, b);
      set_req(i, a, b);
    end
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // all four pending: strict round-robin 0,1,2,3,0
    serve(0, 0);
    gen(a, b);
    set_req(0, a, b);
    serve(1, 0);
    serve(2, 0);
    serve(3, 0);
    serve(0, 0);

    set_req(2, 16'h6482, 16'h6262);
    serve(2, 0);
    set_req(0, 16'hA5A5, 16'hA5A5);
    serve(0, 0);
    set_req(1, 16'h0001, 16'h8000);
    serve(1, 5);

    // abort a compare mid-shift
    set_req(2, 16'h1234, 16'h1235);
    #1;
    chk("abort_ready", 32'(bus.req_ready), 32'b0100);
    @(posedge clk);
    #1;
    drop_req(2);
    repeat (7) @(posedge clk);
    @(negedge clk);
    gen(a, b);
    set_req(0, a, b);
    rst = 1'b0;
    #1;
    chk_zero("abort");
    drop_req(0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rr  = 0;
    bad = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.busy) bad = 1'b1;
    end
    chk("abort_no_rsp", 32'(bad), 32'd0);
    gen(a, b);
    set_req(3, a, b);
    gen(a, b);
    set_req(1, a, b);
    serve(1, 0);
    serve(3, 0);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i] && $urandom_range(0, 1) == 1) begin
          gen(a, b);
          set_req(i, a, b);
        end else if (pend_v[i] && $urandom_range(0, 7) == 0) begin
          drop_req(i);
        end
      end
      if (pick() < 0) begin
        gen(a, b);
        set_req($urandom_range(0, N-1), a, b);
      end
      serve(pick(), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
